// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch front end: program counter, run-time writable branch
//   target LUT, IF/ID pipeline register, halt detection and a saturating
//   retired-instruction counter. Instruction memory is external and
//   combinational: imem_addr is the PC register, imem_data returns the same
//   cycle.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   stall                 hold PC and IF/ID
//   br_taken/br_rel/br_idx   branch in ID: taken flag, relative flag, LUT index
//   lut_we/lut_waddr/lut_wdata   LUT write port
//   imem_addr / imem_data fetch address (PC) / fetched instruction
//   id_instr/id_pc/id_valid  IF/ID register contents
//   retired               count of instructions that left ID (saturating)
//   done                  sticky halt flag
module fetch_stage #(
    parameter int D  = 10,
    parameter int W  = 9,
    parameter int L  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          br_taken,
    input  logic          br_rel,
    input  logic [L-1:0]  br_idx,
    input  logic          lut_we,
    input  logic [L-1:0]  lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  imem_addr,
    input  logic [W-1:0]  imem_data,
    output logic [W-1:0]  id_instr,
    output logic [D-1:0]  id_pc,
    output logic          id_valid,
    output logic [CW-1:0] retired,
    output logic          done
);

    localparam int N = 2**L;

    // Action taken at the next edge, in priority order.
    typedef enum logic [2:0] {
        A_FROZEN,   // done already set: everything holds, ID bubbles
        A_HALT,     // halt pattern in ID: set done, hold like a stall
        A_BRANCH,   // taken branch: redirect PC, flush ID
        A_STALL,    // hold PC and IF/ID
        A_RUN       // sequential fetch
    } action_t;

    typedef struct packed {
        logic [W-1:0] instr;
        logic [D-1:0] pc;
        logic         valid;
    } ifid_t;

    logic [N-1:0][D-1:0] lut;
    logic [D-1:0]        pc_q, pc_nx;
    ifid_t               ifid_q, ifid_nx;
    logic [CW-1:0]       ret_q, ret_nx;
    logic                done_q, done_nx;

    logic                is_halt_instr;
    logic                halt_det;
    logic                br_go;
    logic                ret_inc;
    logic [D-1:0]        lut_rd;
    logic [D-1:0]        br_tgt;
    action_t             action;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign is_halt_instr = (ifid_q.instr == {W{1'b1}});
    assign halt_det      = ifid_q.valid && is_halt_instr && !done_q;
    assign br_go         = br_taken && ifid_q.valid && !done_q;

    // LUT read is combinational from the registered array, so a write on the
    // same edge is not visible until the following cycle.
    assign lut_rd = lut[br_idx];

    // Relative targets: D-bit two's-complement offset, sum wraps mod 2^D.
    assign br_tgt = br_rel ? (ifid_q.pc + lut_rd) : lut_rd;

    // An instruction leaves ID whenever the register is not held; a branch
    // that wins over a simultaneous stall is not counted.
    assign ret_inc = ifid_q.valid && !stall && !done_q && !is_halt_instr;

    always_comb begin
        action = A_RUN;
        if (done_q)
            action = A_FROZEN;
        else if (halt_det)
            action = A_HALT;    // a halt instruction is never a branch
        else if (br_go)
            action = A_BRANCH;
        else if (stall)
            action = A_STALL;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        pc_nx   = pc_q;
        ifid_nx = ifid_q;
        done_nx = done_q;
        ret_nx  = ret_q;

        case (action)
            A_FROZEN: begin
                ifid_nx.valid = 1'b0;
            end
            A_HALT: begin
                done_nx       = 1'b1;
                ifid_nx.valid = 1'b0;
            end
            A_BRANCH: begin
                pc_nx         = br_tgt;
                ifid_nx.valid = 1'b0;
            end
            A_STALL: begin
                // hold
            end
            A_RUN: begin
                pc_nx         = pc_q + 1'b1;
                ifid_nx.instr = imem_data;
                ifid_nx.pc    = pc_q;
                ifid_nx.valid = 1'b1;
            end
            default: begin
                // hold
            end
        endcase

        if (ret_inc && (ret_q != {CW{1'b1}}))
            ret_nx = ret_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= '0;
            ifid_q <= '0;
            ret_q  <= '0;
            done_q <= 1'b0;
        end else begin
            pc_q   <= pc_nx;
            ifid_q <= ifid_nx;
            ret_q  <= ret_nx;
            done_q <= done_nx;
        end
    end

    // LUT writes are independent of stall/done; reset still wins.
    always_ff @(posedge clk) begin
        if (reset)
            lut <= '0;
        else if (lut_we)
            lut[lut_waddr] <= lut_wdata;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr = pc_q;
    assign id_instr  = ifid_q.instr;
    assign id_pc     = ifid_q.pc;
    assign id_valid  = ifid_q.valid;
    assign retired   = ret_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// stimulus, all checked every cycle against an integer reference model.
module tb_fetch_stage;

    localparam int D  = 10;
    localparam int W  = 9;
    localparam int L  = 4;
    localparam int CW = 5;             // small so saturation is reachable
    localparam int ND = 1 << D;
    localparam int NL = 1 << L;
    localparam int RMAX = (1 << CW) - 1;
    localparam int HALT_I = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          br_taken = 1'b0;
    logic          br_rel = 1'b0;
    logic [L-1:0]  br_idx = '0;
    logic          lut_we = 1'b0;
    logic [L-1:0]  lut_waddr = '0;
    logic [D-1:0]  lut_wdata = '0;
    logic [D-1:0]  imem_addr;
    logic [W-1:0]  imem_data;
    logic [W-1:0]  id_instr;
    logic [D-1:0]  id_pc;
    logic          id_valid;
    logic [CW-1:0] retired;
    logic          done;

    logic [W-1:0]  imem [0:ND-1];
    assign imem_data = imem[imem_addr];

    fetch_stage #(.D(D), .W(W), .L(L), .CW(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_rel(br_rel), .br_idx(br_idx),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .retired(retired), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_pc = 0, m_instr = 0, m_idpc = 0, m_valid = 0, m_ret = 0, m_done = 0;
    int m_lut [NL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the architectural rules, advance, compare.
    task automatic cyc();
        int n_pc, n_instr, n_idpc, n_valid, n_ret, n_done;
        int n_lut [NL];
        n_pc = m_pc; n_instr = m_instr; n_idpc = m_idpc;
        n_valid = m_valid; n_ret = m_ret; n_done = m_done;
        n_lut = m_lut;
        if (reset) begin
            n_pc = 0; n_instr = 0; n_idpc = 0; n_valid = 0; n_ret = 0; n_done = 0;
            foreach (n_lut[i]) n_lut[i] = 0;
        end else begin
            if (lut_we) n_lut[lut_waddr] = lut_wdata;
            if (m_valid != 0 && !stall && m_done == 0 && m_instr != HALT_I)
                n_ret = (m_ret >= RMAX) ? RMAX : m_ret + 1;
            if (m_done != 0) begin
                n_valid = 0;
            end else if (m_valid != 0 && m_instr == HALT_I) begin
                n_done = 1;
                n_valid = 0;
            end else if (br_taken && m_valid != 0) begin
                // unsigned modular add == two's-complement add in D bits
                n_pc = br_rel ? (m_idpc + m_lut[br_idx]) % ND : m_lut[br_idx];
                n_valid = 0;
            end else if (!stall) begin
                n_instr = imem[m_pc];
                n_idpc = m_pc;
                n_valid = 1;
                n_pc = (m_pc + 1) % ND;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_idpc = n_idpc;
        m_valid = n_valid; m_ret = n_ret; m_done = n_done;
        m_lut = n_lut;
        chk("imem_addr", 32'(imem_addr), m_pc);
        chk("id_instr", 32'(id_instr), m_instr);
        chk("id_pc", 32'(id_pc), m_idpc);
        chk("id_valid", 32'(id_valid), m_valid);
        chk("retired", 32'(retired), m_ret);
        chk("done", 32'(done), m_done);
    endtask

    task automatic idle();
        stall = 1'b0; br_taken = 1'b0; br_rel = 1'b0; br_idx = '0;
        lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic fill_imem();
        for (int a = 0; a < ND; a++)
            imem[a] = ((a % (1 << W)) == HALT_I) ? '0 : W'(a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (m_lut[i]) m_lut[i] = 0;
        fill_imem();

        // reset state
        do_reset();
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_ret", 32'(retired), 0);
        chk("rst_done", 32'(done), 0);

        // sequential fetch
        cyc();
        chk("seq_e1_pc", 32'(id_pc), 0);
        chk("seq_e1_valid", 32'(id_valid), 1);
        repeat (4) cyc();
        chk("seq_e5_pc", 32'(id_pc), 4);
        chk("seq_e5_addr", 32'(imem_addr), 5);
        chk("seq_e5_ret", 32'(retired), 4);

        // stall while id_pc=2
        do_reset();
        repeat (3) cyc();
        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_addr", 32'(imem_addr), 3);
            chk("stall_pc", 32'(id_pc), 2);
            chk("stall_ret", 32'(retired), 2);
        end
        stall = 1'b0;
        cyc();
        chk("stall_rel_pc", 32'(id_pc), 3);

        // absolute branch with flush
        lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 10'h100;
        cyc();
        idle();
        for (int k = 0; k < 20 && !(m_valid != 0 && m_idpc == 7); k++) cyc();
        chk("abs_reach", 32'(id_pc), 7);
        br_taken = 1'b1; br_rel = 1'b0; br_idx = 4'd5;
        cyc();
        idle();
        chk("abs_tgt", 32'(imem_addr), 10'h100);
        chk("abs_flush", 32'(id_valid), 0);
        cyc();
        chk("abs_id_pc", 32'(id_pc), 10'h100);
        chk("abs_id_valid", 32'(id_valid), 1);

        // relative negative branch with wrap, taken despite stall
        do_reset();
        lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 10'h3FE;
        cyc();
        idle();
        cyc();
        chk("rel_pc1", 32'(id_pc), 1);
        br_taken = 1'b1; br_rel = 1'b1; br_idx = 4'd2; stall = 1'b1;
        cyc();
        idle();
        chk("rel_tgt", 32'(imem_addr), 10'h3FF);
        chk("rel_flush", 32'(id_valid), 0);
        cyc();
        chk("rel_id_pc", 32'(id_pc), 10'h3FF);

        // LUT same-cycle write/read (also crosses the PC wrap)
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h020;
        cyc();
        idle();
        chk("wrap_id_pc", 32'(id_pc), 0);
        br_taken = 1'b1; br_idx = 4'd3;
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h050;
        cyc();
        idle();
        chk("lut_old", 32'(imem_addr), 10'h020);
        cyc();
        br_taken = 1'b1; br_idx = 4'd3;
        cyc();
        idle();
        chk("lut_new", 32'(imem_addr), 10'h050);

        // halt
        imem[6] = W'(HALT_I);
        do_reset();
        lut_we = 1'b1; lut_waddr = 4'd9; lut_wdata = 10'h0AB;
        cyc();
        idle();
        for (int k = 0; k < 20 && m_done == 0; k++) cyc();
        chk("halt_done", 32'(done), 1);
        chk("halt_valid", 32'(id_valid), 0);
        chk("halt_addr", 32'(imem_addr), 7);
        chk("halt_ret", 32'(retired), 6);
        chk("halt_id_pc", 32'(id_pc), 6);
        br_taken = 1'b1; br_idx = 4'd9;
        repeat (3) cyc();
        chk("halt_br_addr", 32'(imem_addr), 7);
        chk("halt_br_ret", 32'(retired), 6);
        reset = 1'b1;
        cyc();
        chk("halt_rst_done", 32'(done), 0);
        chk("halt_rst_addr", 32'(imem_addr), 0);
        chk("halt_rst_ret", 32'(retired), 0);
        reset = 1'b0;
        br_taken = 1'b0;
        cyc();
        br_taken = 1'b1; br_rel = 1'b0; br_idx = 4'd9;
        cyc();
        idle();
        chk("lut_cleared", 32'(imem_addr), 0);
        imem[6] = 9'd6;

        // counter saturation
        do_reset();
        repeat (40) cyc();
        chk("ret_sat", 32'(retired), RMAX);

        // randomized
        for (int a = 0; a < ND; a++)
            imem[a] = ($urandom_range(99) < 2) ? W'(HALT_I) : W'($urandom_range(HALT_I - 1));
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(199) < 3);
            stall     = ($urandom_range(3) == 0);
            br_taken  = ($urandom_range(4) == 0);
            // keep branches out of the cycle where a halt sits in ID
            if (m_valid != 0 && m_done == 0 && m_instr == HALT_I) br_taken = 1'b0;
            br_rel    = $urandom_range(1) != 0;
            br_idx    = L'($urandom_range(NL - 1));
            lut_we    = ($urandom_range(9) < 3);
            lut_waddr = L'($urandom_range(NL - 1));
            lut_wdata = D'($urandom_range(ND - 1));
            cyc();
        end
        idle();
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch front end for the next-generation pipelined core. Holds the program counter, a run-time-writable branch-target LUT and the IF/ID pipeline register. Provides stall, taken-branch flush with absolute or PC-relative targets, halt detection and a retired-instruction counter. Instruction memory sits outside the block: `imem_addr` drives it, and its combinational `imem_data` returns in the same cycle.

## Interface
- `D`, 10: program-counter width; address space is 2^D instructions.
- `W`, 9: instruction width.
- `L`, 4: LUT index width; the LUT holds 2^L entries of D bits.
- `CW`, 16: retired-counter width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: hold PC and IF/ID contents.
- `br_taken` input 1: branch in ID is taken; honoured only when `id_valid`=1.
- `br_rel` input 1: 1 = PC-relative target, 0 = absolute target.
- `br_idx` input L: LUT index for the branch target.
- `lut_we` input 1: LUT write enable.
- `lut_waddr` input L: LUT write index.
- `lut_wdata` input D: LUT write data.
- `imem_addr` output D: fetch address, equal to the PC register.
- `imem_data` input W: instruction at `imem_addr`.
- `id_instr` output W: instruction in ID.
- `id_pc` output D: address of `id_instr`.
- `id_valid` output 1: ID holds a real instruction, not a bubble.
- `retired` output CW: count of instructions that left ID.
- `done` output 1: sticky halt flag.

## Operation
- Reset values: PC=0, `id_instr`=0, `id_pc`=0, `id_valid`=0, `retired`=0, `done`=0, all LUT entries=0.
- Branch qualification: `br_go` = `br_taken` & `id_valid` & !`done`.
- Target when `br_rel`=0: `lut[br_idx]`.
- Target when `br_rel`=1: `id_pc + lut[br_idx]`. The LUT value is two's-complement D-bit; the sum is D bits and wraps modulo 2^D.
- Per-edge priority: reset > done > br_go > stall > normal.
- When `done` is set: PC, `id_instr`, `id_pc` and `retired` hold; `id_valid` is forced to 0.
- `br_go`: PC <= target and `id_valid` <= 0 (flush). This overrides `stall`.
- `stall` (no `br_go`): PC and the IF/ID register hold.
- Normal cycle:
  - PC <= PC+1, wrapping from 2^D-1 to 0.
  - `id_instr` <= `imem_data`, `id_pc` <= PC, `id_valid` <= 1.
- Halt: if `id_valid`=1, `id_instr` is all-ones and `done`=0, then `done` <= 1 at the next edge.
  - That edge is otherwise treated as a stall; PC does not advance.
  - `done` clears only on reset.
- Retired counter:
  - Increments when `id_valid`=1, !`stall`, !`done`, and `id_instr` is not the halt pattern.
  - A taken branch counts as retired.
  - Saturates at 2^CW-1.
- LUT:
  - Write on the edge when `lut_we`=1.
  - A read of the entry being written in the same cycle returns the old value.
  - Writes are honoured even while `done` or `stall` is asserted.

## Timing
- `imem_addr` is driven directly by the PC register; the block has no combinational path from inputs to `imem_addr`.
- Fetch latency: an instruction at address A appears in `id_instr` one edge after PC=A.
- Taken-branch penalty: exactly one bubble. The target instruction is in ID two edges after the branch was in ID.
- `done` rises one edge after the halt instruction is in ID with `id_valid`=1.
- Reset mid-run: on the next edge every output and the LUT return to their reset values, regardless of other inputs.

## Test plan
- Sequential fetch:
  - Stimulus: deassert reset, imem returns instruction = address, no stall.
  - Required: edge 1 gives `id_pc`=0, `id_valid`=1; edge 5 gives `id_pc`=4, `imem_addr`=5, `retired`=4.
- Stall:
  - Stimulus: `stall`=1 for 3 cycles while `id_pc`=2.
  - Required: `imem_addr`=3 and `id_pc`=2 held, `retired` unchanged; after release, the next edge gives `id_pc`=3.
- Absolute branch with flush:
  - Stimulus: write `lut[5]`=0x100, then `br_taken`=1, `br_rel`=0, `br_idx`=5 with `id_pc`=7.
  - Required: next edge gives PC=0x100, `id_valid`=0; following edge gives `id_pc`=0x100.
- Relative negative branch with wrap:
  - Stimulus: `lut[2]`=0x3FE (-2), `id_pc`=1, `br_rel`=1.
  - Required: PC=0x3FF.
  - Stimulus: `br_taken`=1 with `stall`=1.
  - Required: branch still taken.
- LUT same-cycle write/read:
  - Stimulus: write `lut[3]`=0x050 on the same edge as a branch via index 3, whose old value is 0x020.
  - Required: PC=0x020; a later branch via index 3 reaches 0x050.
- Halt:
  - Stimulus: imem returns 0x1FF at address 6.
  - Required: `done`=1 one edge after `id_pc`=6; `id_valid`=0; PC frozen at 7; `retired`=6 frozen; `br_taken` ignored; reset clears everything.
